// File: rtl/alu_datapath_pkg.sv
// Shared types for the ALU datapath: instruction field encodings, status flags
// and sequencer states.
package alu_datapath_pkg;

  // Operand pair (R,S) selection, I[2:0].
  typedef enum logic [2:0] {
    SrcAq, SrcAb, SrcZq, SrcZb, SrcZa, SrcDa, SrcDq, SrcDz
  } src_e;

  // ALU function, I[5:3].
  typedef enum logic [2:0] {
    FnAdd, FnSubr, FnSubs, FnOr, FnAnd, FnNotrs, FnExor, FnExnor
  } fn_e;

  // Destination / shift control, I[8:6].
  typedef enum logic [2:0] {
    DstQreg, DstNop, DstRama, DstRamf, DstRamqd, DstRamd, DstRamqu, DstRamu
  } dst_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: two read ports, one write port, reset-cleared register array.
// With ALU_DATAPATH_PARITY_EN defined, stores even parity per byte and flags
// mismatches on each read port.
module alu_regfile #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_a,
`ifdef ALU_DATAPATH_PARITY_EN
  output logic             perr_a,
  output logic             perr_b,
`endif
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREGS];

  // Register array write; reads below see the pre-edge contents.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];

`ifdef ALU_DATAPATH_PARITY_EN
  localparam int unsigned NB = WIDTH / 8;

  logic [NB-1:0] par [NREGS];

  function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] v);
    logic [NB-1:0] p;
    for (int i = 0; i < int'(NB); i++) p[i] = ^v[8*i +: 8];
    return p;
  endfunction

  // Parity shadow written alongside the data.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < int'(NREGS); i++) par[i] <= '0;
    end else if (we) begin
      par[waddr] <= byte_par(wdata);
    end
  end

  assign perr_a = |(byte_par(rdata_a) ^ par[addr_a]);
  assign perr_b = |(byte_par(rdata_b) ^ par[addr_b]);
`endif

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: bit-slice style ALU with register file, Q register, machine and
// micro status registers, and a repeat sequencer (IDLE/RUN/DONE).
// Optional feature macro: ALU_DATAPATH_PARITY_EN (per-byte parity, sticky perr).
module alu_datapath
  import alu_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 16
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic [8:0]       I,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic [WIDTH-1:0] D,
  input  logic             C0,
  input  logic             mode32,
  input  logic             nCEM,
  input  logic             nCEN,
  input  logic             start,
  input  logic [5:0]       count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic [3:0]       flags,
  output logic [3:0]       msr,
  output logic [3:0]       usr,
  output logic             perr
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned AW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [WIDTH-1:0] LoMask = {{HALF{1'b0}}, {HALF{1'b1}}};

  state_e           state_q;
  logic             busy_q, done_q;
  logic [5:0]       cnt_q;
  logic [8:0]       lat_i;
  logic [3:0]       lat_a, lat_b;
  logic             lat_c0;

  logic [8:0]       ex_i;
  logic [3:0]       ex_a, ex_b;
  logic             ex_c0, run, exec_en;
  src_e             src;
  fn_e              fn;
  dst_e             dst;
  logic [WIDTH-1:0] mask, ra, rb, q_q, q_d, r, s, op_a, op_b, lres, f, rf_wd;
  logic [WIDTH:0]   sum;
  logic             arith, a_msb, b_msb, f_msb, rf_we, q_we;
  flags_t           fl;
  logic [3:0]       msr_q, usr_q;
`ifdef ALU_DATAPATH_PARITY_EN
  logic             perr_a, perr_b;
`endif

  // In RUN the latched instruction drives the datapath; otherwise the live one.
  assign run   = (state_q == StRun);
  assign ex_i  = run ? lat_i  : I;
  assign ex_a  = run ? lat_a  : A;
  assign ex_b  = run ? lat_b  : B;
  assign ex_c0 = run ? lat_c0 : C0;
  assign src   = src_e'(ex_i[2:0]);
  assign fn    = fn_e'(ex_i[5:3]);
  assign dst   = dst_e'(ex_i[8:6]);
  assign mask  = mode32 ? LoMask : '1;

  // The start cycle only latches the instruction; DONE never writes.
  assign exec_en = run | ((state_q == StIdle) & ~start);

  alu_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS),
    .AW   (AW)
  ) u_regfile (
    .clk    (clk),
    .nRESET (nRESET),
    .addr_a (ex_a[AW-1:0]),
    .addr_b (ex_b[AW-1:0]),
    .we     (rf_we & exec_en),
    .waddr  (ex_b[AW-1:0]),
    .wdata  (rf_wd),
    .rdata_a(ra),
`ifdef ALU_DATAPATH_PARITY_EN
    .perr_a (perr_a),
    .perr_b (perr_b),
`endif
    .rdata_b(rb)
  );

  // Operand pair selection.
  always_comb begin
    r = '0;
    s = '0;
    unique case (src)
      SrcAq:   begin r = ra; s = q_q; end
      SrcAb:   begin r = ra; s = rb;  end
      SrcZq:   s = q_q;
      SrcZb:   s = rb;
      SrcZa:   s = ra;
      SrcDa:   begin r = D;  s = ra;  end
      SrcDq:   begin r = D;  s = q_q; end
      SrcDz:   r = D;
      default: ;
    endcase
  end

  // Adder operand conditioning and logic results.
  always_comb begin
    op_a  = '0;
    op_b  = '0;
    lres  = '0;
    arith = 1'b1;
    unique case (fn)
      FnAdd:   begin op_a = r;  op_b = s;  end
      FnSubr:  begin op_a = ~r; op_b = s;  end
      FnSubs:  begin op_a = r;  op_b = ~s; end
      FnOr:    begin arith = 1'b0; lres = r | s;     end
      FnAnd:   begin arith = 1'b0; lres = r & s;     end
      FnNotrs: begin arith = 1'b0; lres = ~r & s;    end
      FnExor:  begin arith = 1'b0; lres = r ^ s;     end
      FnExnor: begin arith = 1'b0; lres = ~(r ^ s);  end
      default: ;
    endcase
    // Masking after inversion makes sum[HALF] the carry out of bit HALF-1.
    op_a = op_a & mask;
    op_b = op_b & mask;
  end

  assign sum   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, ex_c0};
  assign f     = (arith ? sum[WIDTH-1:0] : lres) & mask;
  assign a_msb = mode32 ? op_a[HALF-1] : op_a[WIDTH-1];
  assign b_msb = mode32 ? op_b[HALF-1] : op_b[WIDTH-1];
  assign f_msb = mode32 ? f[HALF-1]    : f[WIDTH-1];
  assign fl.c  = arith & (mode32 ? sum[HALF] : sum[WIDTH]);
  assign fl.v  = arith & (a_msb == b_msb) & (f_msb != a_msb);
  assign fl.n  = f_msb;
  assign fl.z  = ~|f;
  assign flags = fl;

  // Destination decode: register/Q write data and Y source.
  always_comb begin
    rf_we = 1'b0;
    rf_wd = f;
    q_we  = 1'b0;
    q_d   = f;
    Y     = f;
    unique case (dst)
      DstQreg:  q_we = 1'b1;
      DstNop:   ;
      DstRama:  begin rf_we = 1'b1; Y = ra & mask; end
      DstRamf:  rf_we = 1'b1;
      DstRamqd: begin
        rf_we = 1'b1;
        rf_wd = f >> 1;
        q_we  = 1'b1;
        q_d   = (q_q & mask) >> 1;
      end
      DstRamd:  begin rf_we = 1'b1; rf_wd = f >> 1; end
      DstRamqu: begin
        rf_we = 1'b1;
        rf_wd = (f << 1) & mask;
        q_we  = 1'b1;
        q_d   = ((q_q & mask) << 1) & mask;
      end
      DstRamu:  begin rf_we = 1'b1; rf_wd = (f << 1) & mask; end
      default:  ;
    endcase
  end

  // Q register.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) q_q <= '0;
    else if (q_we & exec_en) q_q <= q_d;
  end

  // Status registers load the live flags in every state.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      msr_q <= '0;
      usr_q <= '0;
    end else begin
      if (!nCEM) msr_q <= fl;
      if (!nCEN) usr_q <= fl;
    end
  end

  assign msr = msr_q;
  assign usr = usr_q;

  // Repeat sequencer with registered busy/done.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lat_i   <= '0;
      lat_a   <= '0;
      lat_b   <= '0;
      lat_c0  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lat_i  <= I;
            lat_a  <= A;
            lat_b  <= B;
            lat_c0 <= C0;
            cnt_q  <= count;
            if (count == 6'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (cnt_q == 6'd1) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

`ifdef ALU_DATAPATH_PARITY_EN
  localparam int unsigned NB = WIDTH / 8;

  logic [NB-1:0] q_par;
  logic          q_perr, a_used, b_used, q_used, perr_q;

  function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] v);
    logic [NB-1:0] p;
    for (int i = 0; i < int'(NB); i++) p[i] = ^v[8*i +: 8];
    return p;
  endfunction

  // Q parity shadow follows every Q write.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) q_par <= '0;
    else if (q_we & exec_en) q_par <= byte_par(q_d);
  end

  assign q_perr = |(byte_par(q_q) ^ q_par);
  assign a_used = (src inside {SrcAq, SrcAb, SrcZa, SrcDa}) || (dst == DstRama);
  assign b_used = (src inside {SrcAb, SrcZb});
  assign q_used = (src inside {SrcAq, SrcZq, SrcDq}) || (dst inside {DstRamqd, DstRamqu});

  // Sticky parity error, cleared only by reset.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) perr_q <= 1'b0;
    else perr_q <= perr_q | (a_used & perr_a) | (b_used & perr_b) | (q_used & q_perr);
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Directed, table-driven bench for alu_datapath (WIDTH=64, NREGS=16).
module tb_alu_datapath;

  localparam int AQ = 0, AB = 1, ZQ = 2, ZB = 3, ZA = 4, DA = 5, DQ = 6, DZ = 7;
  localparam int ADD = 0, SUBR = 1, SUBS = 2, FOR = 3, FAND = 4, NOTRS = 5, EXOR = 6, EXNOR = 7;
  localparam int QREG = 0, NOP = 1, RAMA = 2, RAMF = 3, RAMQD = 4, RAMD = 5, RAMQU = 6, RAMU = 7;

  logic        clk = 1'b0;
  logic        nRESET;
  logic [8:0]  I;
  logic [3:0]  A, B;
  logic [63:0] D;
  logic        C0, mode32, nCEM, nCEN, start;
  logic [5:0]  count;
  logic        busy, done, perr;
  logic [63:0] Y;
  logic [3:0]  flags, msr, usr;

  alu_datapath #(.WIDTH(64), .NREGS(16)) dut (
    .clk   (clk),
    .nRESET(nRESET),
    .I     (I),
    .A     (A),
    .B     (B),
    .D     (D),
    .C0    (C0),
    .mode32(mode32),
    .nCEM  (nCEM),
    .nCEN  (nCEN),
    .start (start),
    .count (count),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .flags (flags),
    .msr   (msr),
    .usr   (usr),
    .perr  (perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  i;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [63:0] d;
    logic        c0;
    logic        m32;
    logic [63:0] y;
    logic [3:0]  fl;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [8:0] ins(input int s, input int f, input int d);
    logic [8:0] r;
    r = {d[2:0], f[2:0], s[2:0]};
    return r;
  endfunction

  function automatic vec_t mkv(input logic [8:0] i, input logic [3:0] a, input logic [3:0] b,
                               input logic [63:0] d, input logic c0, input logic m32,
                               input logic [63:0] y, input logic [3:0] fl);
    vec_t v;
    v.i = i; v.a = a; v.b = b; v.d = d; v.c0 = c0; v.m32 = m32; v.y = y; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] i, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] d, input logic c0, input logic m32);
    I = i; A = a; B = b; D = d; C0 = c0; mode32 = m32;
  endtask

  initial begin
    nRESET = 1'b0; I = '0; A = '0; B = '0; D = '0; C0 = 1'b0; mode32 = 1'b0;
    nCEM = 1'b1; nCEN = 1'b1; start = 1'b0; count = '0;

    // {I, A, B, D, C0, mode32} -> {Y, flags {C,V,N,Z}}
    vecs[0]  = mkv(ins(DZ, ADD, RAMF), 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0,
                   64'h7FFF_FFFF_FFFF_FFFF, 4'b0000);
    vecs[1]  = mkv(ins(DZ, ADD, RAMF), 0, 2, 64'h1, 0, 0, 64'h1, 4'b0000);
    vecs[2]  = mkv(ins(AB, ADD, RAMF), 1, 2, 0, 0, 0, 64'h8000_0000_0000_0000, 4'b0110);
    vecs[3]  = mkv(ins(ZB, FOR, NOP), 0, 2, 0, 0, 0, 64'h8000_0000_0000_0000, 4'b0010);
    vecs[4]  = mkv(ins(AB, SUBS, NOP), 1, 1, 0, 1, 0, 64'h0, 4'b1001);
    vecs[5]  = mkv(ins(AB, SUBR, NOP), 2, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0110);
    vecs[6]  = mkv(ins(AB, FAND, NOP), 1, 2, 0, 0, 0, 64'h0, 4'b0001);
    vecs[7]  = mkv(ins(AB, NOTRS, NOP), 1, 2, 0, 0, 0, 64'h8000_0000_0000_0000, 4'b0010);
    vecs[8]  = mkv(ins(AB, EXOR, NOP), 1, 2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
    vecs[9]  = mkv(ins(AB, EXNOR, NOP), 1, 2, 0, 0, 0, 64'h0, 4'b0001);
    vecs[10] = mkv(ins(DA, ADD, RAMA), 1, 3, 64'h1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0110);
    vecs[11] = mkv(ins(ZB, FOR, NOP), 0, 3, 0, 0, 0, 64'h8000_0000_0000_0000, 4'b0010);
    vecs[12] = mkv(ins(ZB, FOR, RAMU), 0, 3, 0, 0, 0, 64'h8000_0000_0000_0000, 4'b0010);
    vecs[13] = mkv(ins(ZB, FOR, NOP), 0, 3, 0, 0, 0, 64'h0, 4'b0001);
    vecs[14] = mkv(ins(ZB, FOR, RAMD), 0, 1, 0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0000);
    vecs[15] = mkv(ins(ZB, FOR, NOP), 0, 1, 0, 0, 0, 64'h3FFF_FFFF_FFFF_FFFF, 4'b0000);
    vecs[16] = mkv(ins(DZ, ADD, QREG), 0, 0, 64'h1234, 0, 0, 64'h1234, 4'b0000);
    vecs[17] = mkv(ins(DQ, ADD, NOP), 0, 0, 64'h10, 1, 0, 64'h1245, 4'b0000);
    vecs[18] = mkv(ins(DZ, ADD, RAMF), 0, 4, 64'hDEAD_BEEF_0000_0000, 0, 0,
                   64'hDEAD_BEEF_0000_0000, 4'b0010);
    vecs[19] = mkv(ins(DZ, ADD, RAMF), 0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0, 4'b1001);
    vecs[20] = mkv(ins(ZB, FOR, NOP), 0, 4, 0, 0, 0, 64'h0, 4'b0001);
    vecs[21] = mkv(ins(DZ, FOR, NOP), 0, 0, 64'h0000_0000_8000_0000, 0, 1,
                   64'h8000_0000, 4'b0010);
    vecs[22] = mkv(ins(DZ, FOR, NOP), 0, 0, 64'h8000_0000_0000_0000, 0, 1, 64'h0, 4'b0001);
    vecs[23] = mkv(ins(DZ, ADD, QREG), 0, 0, 64'hC000_0001_8000_0001, 0, 0,
                   64'hC000_0001_8000_0001, 4'b0010);
    vecs[24] = mkv(ins(ZQ, FOR, RAMQU), 0, 5, 0, 0, 1, 64'h8000_0001, 4'b0010);
    vecs[25] = mkv(ins(ZQ, FOR, NOP), 0, 0, 0, 0, 0, 64'h2, 4'b0000);
    vecs[26] = mkv(ins(ZB, FOR, NOP), 0, 5, 0, 0, 0, 64'h2, 4'b0000);

    cyc();
    cyc();
    nRESET = 1'b1;
    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_msr", msr, 0);
    check("reset_usr", usr, 0);
    check("reset_perr", perr, 0);
    check("reset_y", Y, 0);
    check("reset_flags", flags, 4'b0001);
    cyc();

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].i, vecs[k].a, vecs[k].b, vecs[k].d, vecs[k].c0, vecs[k].m32);
      #3;
      check($sformatf("vec%0d_y", k), Y, vecs[k].y);
      check($sformatf("vec%0d_flags", k), flags, vecs[k].fl);
      cyc();
    end

    // Status register load enables.
    drive(ins(DZ, ADD, NOP), 0, 0, 64'h0, 0, 0);
    nCEM = 1'b0;
    cyc();
    nCEM = 1'b1;
    #3;
    check("msr_zero_load", msr, 4'b0001);
    check("usr_unchanged", usr, 4'b0000);
    drive(ins(DZ, FOR, NOP), 0, 0, 64'h8000_0000_0000_0000, 0, 0);
    nCEN = 1'b0;
    cyc();
    nCEN = 1'b1;
    #3;
    check("usr_load", usr, 4'b0010);
    check("msr_held", msr, 4'b0001);
    cyc();

    // Sequencer: Q=8, three RAMQD steps.
    drive(ins(DZ, ADD, QREG), 0, 0, 64'h8, 0, 0);
    cyc();
    drive(ins(ZQ, ADD, RAMQD), 0, 5, 64'h0, 0, 0);
    count = 6'd3;
    start = 1'b1;
    #3;
    check("seq_idle_busy", busy, 0);
    cyc();
    // Live inputs now hostile; start held to show it is ignored.
    drive(ins(DZ, ADD, QREG), 0, 0, 64'hFFFF, 0, 0);
    count = 6'd0;
    for (int k = 0; k < 3; k++) begin
      #3;
      check($sformatf("seq_busy%0d", k), busy, 1);
      check($sformatf("seq_nodone%0d", k), done, 0);
      cyc();
    end
    #3;
    check("seq_done_pulse", done, 1);
    check("seq_busy_off", busy, 0);
    cyc();
    drive(ins(ZQ, FOR, NOP), 0, 0, 64'h0, 0, 0);
    start = 1'b0;
    #3;
    check("seq_done_once", done, 0);
    check("seq_idle_after", busy, 0);
    check("seq_q_final", Y, 64'h1);
    cyc();
    drive(ins(ZB, FOR, NOP), 0, 5, 64'h0, 0, 0);
    #3;
    check("seq_r5_final", Y, 64'h1);
    cyc();

    // count=0: straight to DONE, nothing executed.
    drive(ins(DZ, ADD, QREG), 0, 0, 64'h55, 0, 0);
    count = 6'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    drive(ins(ZQ, FOR, NOP), 0, 0, 64'h0, 0, 0);
    #3;
    check("cnt0_done", done, 1);
    check("cnt0_busy", busy, 0);
    check("cnt0_q_kept", Y, 64'h1);
    cyc();
    #3;
    check("cnt0_done_off", done, 0);
    cyc();

    // Reset during RUN.
    drive(ins(DZ, ADD, RAMF), 0, 6, 64'h8000_0000_0000_0000, 0, 0);
    nCEM = 1'b0;
    cyc();
    nCEM = 1'b1;
    drive(ins(ZQ, FOR, NOP), 0, 0, 64'h0, 0, 0);
    count = 6'd10;
    start = 1'b1;
    cyc();
    start = 1'b0;
    #3;
    check("rst_run_busy", busy, 1);
    cyc();
    #2;
    nRESET = 1'b0;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_msr", msr, 0);
    check("rst_async_q", Y, 0);
    cyc();
    nRESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      check($sformatf("rst_nodone%0d", k), done, 0);
      cyc();
    end
    drive(ins(ZB, FOR, NOP), 0, 6, 64'h0, 0, 0);
    #3;
    check("rst_r6_clear", Y, 0);
    cyc();
    drive(ins(ZB, FOR, NOP), 0, 5, 64'h0, 0, 0);
    #3;
    check("rst_r5_clear", Y, 0);
    cyc();

`ifdef ALU_DATAPATH_PARITY_EN
    drive(ins(DZ, ADD, RAMF), 0, 3, 64'h0F, 0, 0);
    cyc();
    dut.u_regfile.mem[3][0] = 1'b0;
    drive(ins(ZA, FOR, NOP), 3, 0, 64'h0, 0, 0);
    cyc();
    #3;
    check("perr_set", perr, 1);
    drive(ins(ZB, FOR, NOP), 0, 0, 64'h0, 0, 0);
    cyc();
    cyc();
    #3;
    check("perr_sticky", perr, 1);
    nRESET = 1'b0;
    #1;
    check("perr_reset", perr, 0);
    cyc();
    nRESET = 1'b1;
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 64, total datapath width; a multiple of 8, minimum 16.
REQ-002 SHALL have parameter NREGS, default 16, register-file depth; a power of 2, at most 16.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge.
REQ-004 SHALL have ports: nRESET  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: I  in  9  instruction; I[2:0] source, I[5:3] function, I[8:6] destination.
REQ-006 SHALL have ports: A, B  in  4 each  register addresses; only the low log2(NREGS) bits are used.
REQ-007 SHALL have ports: D  in  WIDTH  external data; C0  in  1  carry-in; mode32  in  1  selects active width WIDTH/2.
REQ-008 SHALL have ports: nCEM, nCEN  in  1 each  machine and micro status load enables, active-low.
REQ-009 SHALL have ports: start  in  1  sequencer start; count  in  6  step count.
REQ-010 SHALL have ports: busy, done  out  1 each; Y  out  WIDTH  result bus; flags  out  4  live {C,V,N,Z}.
REQ-011 SHALL have ports: msr, usr  out  4 each  status registers {C,V,N,Z}; perr  out  1  parity error (macro only).

Function
REQ-012 Sources SHALL be 0:AQ 1:AB 2:0Q 3:0B 4:0A 5:DA 6:DQ 7:D0, giving operand pairs (R,S).
REQ-013 Functions SHALL be 0:R+S+C0 1:S+~R+C0 2:R+~S+C0 3:R|S 4:R&S 5:~R&S 6:R^S 7:~(R^S).
REQ-014 Destinations SHALL be 0:F->Q, Y=F; 1:Y=F, no write; 2:F->B, Y=A; 3:F->B, Y=F; 4:F>>1->B, Q>>1->Q; 5:F>>1->B; 6:F<<1->B, Q<<1->Q; 7:F<<1->B; for 4..7, Y=F.
REQ-015 Shifts SHALL shift in 0 and operate over the active width.
REQ-016 With mode32=1, all operations SHALL use bits [WIDTH/2-1:0], and written values and Y SHALL have zero upper halves.
REQ-017 Flags SHALL be computed combinationally: C = carry out of the active MSB; V = signed overflow; N = active MSB of F; Z = F zero over the active width.
REQ-018 For logic functions, C and V SHALL be 0.
REQ-019 Register and Q writes SHALL take effect at the rising clk edge; reads are combinational, and a read of the register written in the same cycle returns the old value.
REQ-020 On a clk edge with nCEM=0, flags SHALL load into msr; with nCEN=0, flags SHALL load into usr; both may load in the same cycle.
REQ-021 The sequencer SHALL have states IDLE, RUN and DONE.
REQ-022 In IDLE, the live I/A/B/C0 SHALL execute every cycle.
REQ-023 start=1 in IDLE SHALL latch I, A, B, C0 and count; count=0 SHALL go directly to DONE with no step executed; otherwise the sequencer enters RUN.
REQ-024 In RUN, the latched instruction SHALL execute once per cycle for count cycles, the live I/A/B/C0 SHALL be ignored, and busy=1; then the sequencer enters DONE.
REQ-025 In DONE, done=1 for exactly one cycle, no register write occurs, and the next state is IDLE.
REQ-026 start SHALL be ignored while busy=1 or in DONE.
REQ-027 D, mode32, nCEM and nCEN SHALL remain live in all states.

Reset
REQ-028 nRESET=0 SHALL asynchronously clear all registers, Q, msr, usr and perr; set state IDLE; and drive busy=0, done=0.
REQ-029 Reset asserted during RUN SHALL abort the sequence with no done pulse.

Configuration
REQ-030 With ALU_DATAPATH_PARITY_EN defined, each register and Q SHALL store even parity per byte, and perr SHALL set sticky on any parity mismatch in a used A/B/Q read; it clears only on reset.
REQ-031 Without ALU_DATAPATH_PARITY_EN, no parity storage SHALL exist and perr SHALL be tied 0.

Structure
REQ-032 Package alu_datapath_pkg SHALL hold the source, function and destination enums, the flags struct {C,V,N,Z} and the sequencer state enum.
REQ-033 The register file, with two read ports, one write port and optional parity, SHALL be sub-module alu_regfile.

Verification
REQ-034 Add 64-bit: R1=0x7FFF_FFFF_FFFF_FFFF, R2=1, I=AB/ADD/RAMF, A=1, B=2, C0=0 -> R2=0x8000_0000_0000_0000, flags V=1, N=1, C=0, Z=0.
REQ-035 mode32: D=0xFFFF_FFFF_FFFF_FFFF, I=D0/ADD/RAMF, C0=1 -> RB=0, C=1, Z=1; a live check of N uses only bit 31.
REQ-036 Sequencer: Q=0x8, start with count=3, I=0Q/ADD/RAMQD -> busy for 3 cycles, Q=0x1, then a one-cycle done pulse.
REQ-037 Boundaries: count=0 -> done on the next cycle with no state change; start while busy -> ignored; nRESET low in cycle 2 of RUN -> IDLE, all registers 0, no done pulse.
REQ-038 With parity enabled, forcing a flipped stored bit in R3 and reading A=3 -> perr=1, held until reset.
REQ-039 nCEM=0 and nCEN=1 on an add yielding zero -> msr.Z=1, usr unchanged.
